// File: rtl/axi_burst_read_master_pkg.sv
// rtl/axi_burst_read_master_pkg.sv - shared AXI constants, encodings and FSM state for the burst read master
package axi_burst_read_master_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    SIZE_1B   = 3'd0,
    SIZE_2B   = 3'd1,
    SIZE_4B   = 3'd2,
    SIZE_8B   = 3'd3,
    SIZE_16B  = 3'd4,
    SIZE_32B  = 3'd5,
    SIZE_64B  = 3'd6,
    SIZE_128B = 3'd7
  } axi_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_burst_read_master_if.sv
// rtl/axi_burst_read_master_if.sv - AXI4 read address and read data channels
interface axi_burst_read_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [ID_W-1:0]   ARID;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic [2:0]        ARPROT;

  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [ID_W-1:0]   RID;
  logic [1:0]        RRESP;
  logic              RLAST;

  modport master (
    output ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST, ARPROT, RREADY,
    input  ARREADY, RVALID, RDATA, RID, RRESP, RLAST
  );

  modport slave (
    input  ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST, ARPROT, RREADY,
    output ARREADY, RVALID, RDATA, RID, RRESP, RLAST
  );
endinterface

// File: rtl/axi_rd_skid.sv
// rtl/axi_rd_skid.sv - one-entry valid/ready output register, full throughput when drained each cycle
module axi_rd_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic [W-1:0] s_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [W-1:0] m_tdata
);

  // Accept a new entry whenever the held one leaves in the same cycle.
  assign s_tready = !m_tvalid || m_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
    end else if (s_tvalid && s_tready) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_burst_read_master.sv
// rtl/axi_burst_read_master.sv - single-outstanding AXI4 INCR burst read master with per-beat error flagging
module axi_burst_read_master
  import axi_burst_read_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 4,
  parameter int TXN_ID  = 0,
  parameter int MAX_LEN = 8
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [7:0]             req_len,
  input  logic [2:0]             req_size,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_W-1:0]      resp_data,
  output logic                   resp_last,
  output logic                   resp_err,
  axi_burst_read_master_if.master axi
);

  localparam logic [ID_W-1:0] RID_EXP = ID_W'(TXN_ID);
  localparam logic [7:0]      LEN_CAP = 8'(MAX_LEN - 1);

  rd_state_e         state;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic              ar_valid;
  logic [7:0]        beat_cnt;

  logic skid_in_ready;
  logic r_offer;
  logic r_fire;
  logic at_final;
  logic beat_last;
  logic beat_err;

  assign axi.ARVALID = ar_valid;
  assign axi.ARADDR  = ar_addr;
  assign axi.ARID    = RID_EXP;
  assign axi.ARLEN   = ar_len;
  assign axi.ARSIZE  = ar_size;
  assign axi.ARBURST = BURST_INCR;
  assign axi.ARPROT  = 3'b000;
  assign axi.RREADY  = (state == DATA) && skid_in_ready;

  assign r_offer  = (state == DATA) && axi.RVALID;
  assign r_fire   = axi.RVALID && axi.RREADY;
  assign at_final = (beat_cnt == ar_len);

  // The burst ends at the expected count or at an early RLAST, whichever comes first;
  // any disagreement between the two marks that beat as an error.
  assign beat_last = at_final || axi.RLAST;
  assign beat_err  = resp_is_err(axi.RRESP) || (axi.RID != RID_EXP) || (axi.RLAST != at_final);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      ar_addr   <= '0;
      ar_len    <= '0;
      ar_size   <= '0;
      ar_valid  <= 1'b0;
      beat_cnt  <= '0;
      req_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            ar_addr   <= req_addr;
            ar_len    <= (req_len > LEN_CAP) ? LEN_CAP : req_len;
            ar_size   <= req_size;
            beat_cnt  <= '0;
            ar_valid  <= 1'b1;
            req_ready <= 1'b0;
            state     <= ADDR;
          end else begin
            // Hold off new requests until the last beat has left the output register.
            req_ready <= !(resp_valid && !resp_ready);
          end
        end
        ADDR: begin
          if (axi.ARREADY) begin
            ar_valid <= 1'b0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (r_fire) begin
            if (beat_last) begin
              state <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  axi_rd_skid #(.W(DATA_W + 2)) u_skid (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .s_tvalid (r_offer),
    .s_tready (skid_in_ready),
    .s_tdata  ({beat_err, beat_last, axi.RDATA}),
    .m_tvalid (resp_valid),
    .m_tready (resp_ready),
    .m_tdata  ({resp_err, resp_last, resp_data})
  );

endmodule

// File: tb/tb_axi_burst_read_master.sv
// tb/tb_axi_burst_read_master.sv - randomized scoreboard bench for the AXI burst read master
module tb_axi_burst_read_master;

  localparam int TXN_ID  = 5;
  localparam int MAX_LEN = 8;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        err;
  } beat_t;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        resp_last;
  logic        resp_err;

  int    checks = 0;
  int    errors = 0;
  int    rr_mode = 0;
  int    rr_ph = 0;
  beat_t exp_q[$];

  axi_burst_read_master_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) bus ();

  axi_burst_read_master #(
    .ADDR_W(32), .DATA_W(64), .ID_W(4), .TXN_ID(TXN_ID), .MAX_LEN(MAX_LEN)
  ) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_size   (req_size),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_last  (resp_last),
    .resp_err   (resp_err),
    .axi        (bus)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_arvalid"}, bus.ARVALID, 0);
    chk({tag, "_rready"}, bus.RREADY, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_last"}, resp_last, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_araddr"}, bus.ARADDR, 0);
    chk({tag, "_arlen"}, bus.ARLEN, 0);
    chk({tag, "_arsize"}, bus.ARSIZE, 0);
    chk({tag, "_resp_data"}, resp_data, 0);
  endtask

  // Consumer: 0 = always ready, 1 = pattern 1,0,0 repeating, otherwise random.
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      rr_ph++;
      case (rr_mode)
        0:       resp_ready = 1'b1;
        1:       resp_ready = (rr_ph % 3 == 0);
        default: resp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every accepted response beat is compared against the scoreboard.
  always @(negedge ACLK) begin
    if (ARESETn && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_data", resp_data, e.data);
        chk("beat_last", resp_last, e.last);
        chk("beat_err", resp_err, e.err);
      end
    end
    if (ARESETn && resp_valid && !resp_ready) chk("rready_while_full", bus.RREADY, 0);
  end

  // One transaction: request, AR handshake after ar_wait stalls, then slave R beats.
  // rlast_at = 0 puts RLAST on the expected final beat; abort_at > 0 resets before that beat.
  task automatic run_txn(input logic [31:0] addr, input int len, input int size, input int ar_wait,
                         input logic [63:0] base, input int err_beat, input bit bad_id,
                         input int rlast_at, input bit gaps, input int abort_at);
    int    e, lastpos, cnt, t, stall;
    bit    hit;
    beat_t b;
    e       = ((len > MAX_LEN - 1) ? MAX_LEN - 1 : len) + 1;
    lastpos = (rlast_at == 0) ? e : rlast_at;
    cnt     = (lastpos < e) ? lastpos : e;
    for (int i = 1; i <= cnt; i++) begin
      b.data = base + 64'(i - 1);
      b.last = (i == cnt);
      b.err  = (i == err_beat) || bad_id || ((i == lastpos) != (i == e));
      exp_q.push_back(b);
    end

    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = 8'(len);
    req_size  = 3'(size);
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge ACLK);
      t++;
    end
    chk("req_accept", req_ready, 1);
    @(negedge ACLK);
    req_valid = 1'b0;

    for (int k = 0; k < ar_wait; k++) begin
      chk("arvalid_hold", bus.ARVALID, 1);
      chk("araddr_stable", bus.ARADDR, addr);
      @(negedge ACLK);
    end
    chk("arvalid", bus.ARVALID, 1);
    chk("araddr", bus.ARADDR, addr);
    chk("arlen", bus.ARLEN, 64'(e - 1));
    chk("arsize", bus.ARSIZE, 64'(size));
    chk("arid", bus.ARID, TXN_ID);
    chk("arburst", bus.ARBURST, 1);
    chk("arprot", bus.ARPROT, 0);
    bus.ARREADY = 1'b1;
    @(negedge ACLK);
    bus.ARREADY = 1'b0;
    chk("arvalid_drop", bus.ARVALID, 0);

    stall = 0;
    for (int i = 1; i <= lastpos; i++) begin
      if (gaps) while ($urandom_range(0, 2) == 0) @(negedge ACLK);
      bus.RVALID = 1'b1;
      bus.RDATA  = base + 64'(i - 1);
      bus.RID    = bad_id ? 4'(TXN_ID + 1) : 4'(TXN_ID);
      bus.RRESP  = (i == err_beat) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
      bus.RLAST  = (i == lastpos);
      if (i == abort_at) begin
        ARESETn = 1'b0;
        #1;
        chk_reset_state("midburst");
        exp_q.delete();
        bus.RVALID = 1'b0;
        bus.RLAST  = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        return;
      end
      if (i > cnt) begin
        hit = 0;
        repeat (5) begin
          #1;
          if (bus.RREADY) hit = 1;
          @(negedge ACLK);
        end
        bus.RVALID = 1'b0;
        chk("extra_beat_blocked", hit, 0);
        break;
      end
      t = 0;
      #1;
      while (!bus.RREADY && t < 60) begin
        @(negedge ACLK);
        #1;
        t++;
      end
      if (t >= 60) chk("r_handshake_timeout", 0, 1);
      stall += t;
      @(negedge ACLK);
      bus.RVALID = 1'b0;
    end
    bus.RVALID = 1'b0;
    bus.RLAST  = 1'b0;
    if (rr_mode == 0 && !gaps) chk("no_bubble", stall, 0);

    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge ACLK);
      t++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    t = 0;
    while (!req_ready && t < 10) begin
      @(negedge ACLK);
      t++;
    end
    chk("req_ready_idle", req_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int len, ew, ra;
    ARESETn     = 1'b0;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_len     = '0;
    req_size    = '0;
    bus.ARREADY = 1'b0;
    bus.RVALID  = 1'b0;
    bus.RDATA   = '0;
    bus.RID     = '0;
    bus.RRESP   = '0;
    bus.RLAST   = 1'b0;
    repeat (3) @(negedge ACLK);
    chk_reset_state("por");
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);

    run_txn(32'h8000_0000, 0, 3, 2, 64'h1122334455667788, 0, 0, 0, 0, 0);
    run_txn(32'h0000_1000, 3, 3, 0, 64'h0, 0, 0, 0, 0, 0);
    rr_mode = 1;
    run_txn(32'h0000_2000, 3, 3, 1, 64'hA000, 0, 0, 0, 0, 0);
    rr_mode = 0;
    run_txn(32'h0000_3000, 3, 3, 1, 64'hB000, 2, 0, 0, 0, 0);
    run_txn(32'h0000_4000, 1, 2, 0, 64'hC000, 0, 1, 0, 0, 0);
    run_txn(32'h0000_5000, 3, 3, 0, 64'hD000, 0, 0, 2, 0, 0);
    run_txn(32'h0000_6000, 3, 3, 0, 64'hE000, 0, 0, 0, 0, 2);
    run_txn(32'h0000_7000, 0, 3, 1, 64'hF000, 0, 0, 0, 0, 0);
    run_txn(32'h0000_8000, 20, 3, 0, 64'h100, 0, 0, 0, 0, 0);
    run_txn(32'h0000_9000, 3, 3, 0, 64'h200, 0, 0, 6, 0, 0);

    rr_mode = 2;
    for (int n = 0; n < 16; n++) begin
      len = $urandom_range(0, 12);
      ew  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
      ra  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0;
      run_txn($urandom, len, $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom},
              ew, ($urandom_range(0, 7) == 0), ra, 1'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_burst_read_master.md
Name: axi_burst_read_master

Overview:
- Parametrised successor to the single-beat memory read port: an AXI4 read master with a registered address/data FSM, INCR bursts, an ID field and an error path.
- Accepts one read request per transaction from the LSU/IFU side and returns data beats through a one-entry output register with valid/ready.
- Sits between the core's memory stage and the AXI crossbar or DPI memory model.
- One outstanding transaction at a time.

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 64: data width, a power of two, at least 8.
- ID_W, 4: AXI ID width.
- TXN_ID, 0: constant driven on ARID; also the expected RID.
- MAX_LEN, 8: maximum beats per burst (1..256).

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_addr  in  ADDR_W  start address.
- req_len  in  8  beats minus 1.
- req_size  in  3  AXI size encoding.
- resp_valid  out  1  beat available.
- resp_ready  in  1  consumer accepts the beat.
- resp_data  out  DATA_W  beat data.
- resp_last  out  1  final beat of the transaction.
- resp_err  out  1  beat carries an error.
- ARVALID  out  1.
- ARREADY  in  1.
- ARADDR  out  ADDR_W.
- ARID  out  ID_W.
- ARLEN  out  8.
- ARSIZE  out  3.
- ARBURST  out  2  fixed to INCR (2'b01).
- ARPROT  out  3  fixed to 3'b000.
- RVALID  in  1.
- RREADY  out  1.
- RDATA  in  DATA_W.
- RID  in  ID_W.
- RRESP  in  2.
- RLAST  in  1.

Behaviour:
- Reset, asynchronous on ARESETn low:
  - state = IDLE.
  - ARVALID, RREADY, resp_valid, resp_last and resp_err are 0; req_ready is 0.
  - ARADDR, ARLEN, ARSIZE and resp_data are 0.
  - Beat counter is 0.
  - Reset mid-transaction abandons the burst with no response. The interconnect is reset in the same domain.
- FSM state IDLE:
  - req_ready = 1.
  - On a handshake: latch addr, len (clamped to MAX_LEN-1) and size into the AR registers, clear the counter, go to ADDR.
  - ARVALID rises on the cycle after the handshake, giving a request-to-ARVALID latency of 1.
- FSM state ADDR:
  - ARVALID = 1; ARADDR, ARLEN and ARSIZE stay stable until ARREADY.
  - On ARVALID && ARREADY: go to DATA.
  - No combinational path from ARREADY to ARVALID.
- FSM state DATA:
  - RREADY = !resp_valid || resp_ready.
  - On an R handshake: load RDATA into resp_data, set resp_valid, increment the counter.
  - resp_last = (counter == ARLEN).
  - resp_err = (RRESP[1] != 0) || (RID != TXN_ID) || (RLAST != resp_last).
  - After the final beat is accepted by the R handshake: go to IDLE.
  - req_ready reasserts only once the output register has drained (resp_valid == 0, or its handshake is in the same cycle).
- Output register:
  - resp_valid holds until resp_ready.
  - A new beat and a consumed beat in the same cycle give back-to-back throughput, with no bubble at full rate.
- Early RLAST (RLAST before the expected count): flag resp_err on that beat, force resp_last = 1, return to IDLE.
- Late or missing RLAST: the beat at counter == ARLEN is flagged with resp_err and treated as last; any extra beats are not accepted.
- Counter width is 8 bits and the count never wraps, because it is bounded by ARLEN ≤ 255.
- RVALID outside DATA is ignored; RREADY = 0.
- ARADDR is not incremented locally; the slave owns INCR addressing.

Decomposition:
- Shared package holds:
  - AXI constants: BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - Size encodings.
  - The FSM state enum {IDLE, ADDR, DATA}.
- One natural sub-module, axi_rd_skid: the one-entry output register with valid/ready. It is reusable for the write-response path.

Test Plan:
- Single beat: addr=0x80000000, len=0, size=3; slave ARREADY after 2 cycles, RDATA=0x1122334455667788, RLAST=1 → ARVALID held 3 cycles with stable addr; one resp beat with that data, resp_last=1, resp_err=0; req_ready back in IDLE.
- Burst of 4, resp_ready tied 1, slave streams with RVALID continuous → 4 consecutive resp beats, data 0..3, resp_last only on the 4th, no bubbles.
- Backpressure: 4-beat burst, resp_ready toggles 1,0,0,1… → RREADY low while the register is full; no beat lost or duplicated; order preserved.
- Errors:
  - RRESP=SLVERR on beat 2 of 4 → resp_err=1 only on beat 2.
  - RID=TXN_ID+1 → resp_err=1.
  - RLAST on beat 2 of 4 → beat 2 has resp_err=1 and resp_last=1; FSM returns to IDLE.
- Reset mid-burst: drop ARESETn during beat 2 → all outputs 0 immediately (asynchronous); after release, a new 1-beat request completes normally.
- len=20 with MAX_LEN=8 → ARLEN=7; 8 beats returned.
